// File: rtl/mult_unit_if.sv
// Start/busy/done handshake and operand/result bus of the iterative multiplier.
// master drives requests, slave is the multiplier.
interface mult_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             signed_op;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] operand_b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result_lo;
   logic [WIDTH-1:0] result_hi;

   modport master (
      output start, signed_op,
      output operand_a, operand_b,
      input  busy, done,
      input  result_lo, result_hi
   );

   modport slave (
      input  start, signed_op,
      input  operand_a, operand_b,
      output busy, done,
      output result_lo, result_hi
   );
endinterface

// File: rtl/mult_unit.sv
// Iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Works on magnitudes and applies the sign once at the end.
module mult_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic      clk,
   input  logic      rst_n,
   mult_unit_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_e;

   localparam int PW = 2 * WIDTH;

   state_e           state_q, state_d;
   logic [PW-1:0]    acc_q, acc_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             neg_q, neg_d;
   logic [PW-1:0]    res_q, res_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] a_abs, b_abs;
   logic [WIDTH:0]   sum;
   logic             a_neg, b_neg;

   // 0x8000_0000 negates to itself, which is the correct unsigned 2^31
   assign a_neg = bus.signed_op & bus.operand_a[WIDTH-1];
   assign b_neg = bus.signed_op & bus.operand_b[WIDTH-1];
   assign a_abs = a_neg ? -bus.operand_a : bus.operand_a;
   assign b_abs = b_neg ? -bus.operand_b : bus.operand_b;

   // multiplier lives in the low half and shifts out as the product shifts in
   assign sum = {1'b0, acc_q[PW-1:WIDTH]} + {1'b0, mcand_q};

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      cnt_d   = cnt_q;
      neg_d   = neg_q;
      res_d   = res_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               mcand_d = a_abs;
               acc_d   = {{WIDTH{1'b0}}, b_abs};
               cnt_d   = '0;
               neg_d   = a_neg ^ b_neg;
               state_d = RUN;
            end
         end
         RUN: begin
            if (acc_q[0]) acc_d = {sum, acc_q[WIDTH-1:1]};
            else          acc_d = {1'b0, acc_q[PW-1:1]};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIN;
         end
         FIN: begin
            res_d   = neg_q ? -acc_q : acc_q;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         mcand_q <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         res_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         res_q   <= res_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = done_q;
   assign bus.result_lo = res_q[WIDTH-1:0];
   assign bus.result_hi = res_q[PW-1:WIDTH];
endmodule

// File: tb/tb_mult_unit.sv
// Testbench for mult_unit: vector table, scoreboard queue, corner sequences.
// Expected products come from constants or a 64-bit reference multiply.
module tb_mult_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   mult_unit_if #(.WIDTH(32)) bus ();

   mult_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   logic [63:0] exp_q[$];
   int n_cmp = 0;
   int n_bad = 0;
   int n_done = 0;
   logic done_prev = 1'b0;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] model(
      logic [31:0] a, logic [31:0] b, logic s);
      longint sa, sb;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return 64'(sa * sb);
      end
      return {32'b0, a} * {32'b0, b};
   endfunction

   // scoreboard: every done pulse consumes one expected product
   always @(posedge clk) begin
      #1;
      if (bus.done) begin
         n_done++;
         chk("done_twice", {63'b0, done_prev}, 64'd0);
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
         end else begin
            chk("product", {bus.result_hi, bus.result_lo},
                exp_q.pop_front());
         end
      end
      done_prev = bus.done;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_op(logic [31:0] a, logic [31:0] b,
                           logic s, logic push);
      bus.start     = 1'b1;
      bus.operand_a = a;
      bus.operand_b = b;
      bus.signed_op = s;
      if (push) exp_q.push_back(model(a, b, s));
      tick();
      bus.start = 1'b0;
      bus.operand_a = $urandom;
      bus.operand_b = $urandom;
   endtask

   // called right after the start edge; returns in the done cycle
   task automatic wait_done(string nm);
      int n;
      int bc;
      bit hit;
      n = 0;
      bc = 0;
      hit = 0;
      if (bus.busy) bc++;
      for (int i = 0; i < 100; i++) begin
         tick();
         n++;
         if (bus.done) begin
            hit = 1;
            chk({nm, "_busy_at_done"}, {63'b0, bus.busy}, 64'd0);
            break;
         end
         if (bus.busy) bc++;
      end
      chk({nm, "_timeout"}, {63'b0, hit}, 64'd1);
      chk({nm, "_latency"}, 64'(n), 64'd33);
      chk({nm, "_busy_cycles"}, 64'(bc), 64'd33);
   endtask

   vec_t vt[10];

   initial begin
      int d0;
      vt[0] = '{32'd6, 32'd7, 1'b0, 32'h0, 32'h2A};
      vt[1] = '{32'hFFFFFFFD, 32'd5, 1'b1,
                32'hFFFFFFFF, 32'hFFFFFFF1};
      vt[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0,
                32'hFFFFFFFE, 32'h00000001};
      vt[3] = '{32'h80000000, 32'h80000000, 1'b1,
                32'h40000000, 32'h0};
      vt[4] = '{32'h0, 32'h12345678, 1'b1, 32'h0, 32'h0};
      vt[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h0, 32'h1};
      vt[6] = '{32'h80000000, 32'd2, 1'b0, 32'h1, 32'h0};
      vt[7] = '{32'd7, 32'hFFFFFFFF, 1'b1,
                32'hFFFFFFFF, 32'hFFFFFFF9};
      vt[8] = '{32'h80000000, 32'd1, 1'b1,
                32'hFFFFFFFF, 32'h80000000};
      vt[9] = '{32'hFFFFFFFF, 32'd3, 1'b0, 32'h2, 32'hFFFFFFFD};

      bus.start = 1'b0;
      bus.signed_op = 1'b0;
      bus.operand_a = '0;
      bus.operand_b = '0;
      repeat (2) tick();
      chk("rst_busy", {63'b0, bus.busy}, 64'd0);
      chk("rst_done", {63'b0, bus.done}, 64'd0);
      chk("rst_result", {bus.result_hi, bus.result_lo}, 64'd0);
      rst_n = 1'b1;
      tick();

      // table vectors: constant expectation checked at done
      foreach (vt[i]) begin
         start_op(vt[i].a, vt[i].b, vt[i].s, 1'b0);
         exp_q.push_back({vt[i].hi, vt[i].lo});
         wait_done("vec");
         tick();
         chk("vec_hold", {bus.result_hi, bus.result_lo},
             {vt[i].hi, vt[i].lo});
      end

      // random vectors against the reference multiply
      for (int i = 0; i < 8; i++) begin
         start_op($urandom, $urandom, 1'(i % 2), 1'b1);
         wait_done("rnd");
         repeat (2) tick();
      end

      // start while busy is ignored
      d0 = n_done;
      start_op(32'd2, 32'd3, 1'b0, 1'b1);
      repeat (9) tick();
      start_op(32'd100, 32'd100, 1'b0, 1'b0);
      for (int i = 0; i < 60 && !bus.done; i++) tick();
      chk("ign_lo", {32'b0, bus.result_lo}, 64'd6);
      repeat (40) tick();
      chk("ign_done_cnt", 64'(n_done - d0), 64'd1);

      // back-to-back: start accepted in the done cycle
      start_op(32'd6, 32'd7, 1'b0, 1'b1);
      wait_done("b2b_first");
      chk("b2b_first_lo", {32'b0, bus.result_lo}, 64'd42);
      start_op(32'd4, 32'd4, 1'b0, 1'b1);
      chk("b2b_busy", {63'b0, bus.busy}, 64'd1);
      for (int i = 0; i < 31; i++) begin
         if (bus.result_lo !== 32'd42) begin
            chk("b2b_lo_hold", {32'b0, bus.result_lo}, 64'd42);
         end
         tick();
      end
      chk("b2b_lo_hold_end", {32'b0, bus.result_lo}, 64'd42);
      for (int i = 0; i < 5 && !bus.done; i++) tick();
      chk("b2b_second_done", {63'b0, bus.done}, 64'd1);
      chk("b2b_second_lo", {32'b0, bus.result_lo}, 64'd16);
      repeat (2) tick();

      // asynchronous reset in the middle of RUN
      d0 = n_done;
      start_op(32'd6, 32'd7, 1'b0, 1'b1);
      repeat (14) tick();
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", {63'b0, bus.busy}, 64'd0);
      chk("arst_done", {63'b0, bus.done}, 64'd0);
      chk("arst_result", {bus.result_hi, bus.result_lo}, 64'd0);
      exp_q.delete();
      #2 rst_n = 1'b1;
      tick();
      repeat (40) tick();
      chk("arst_no_done", 64'(n_done - d0), 64'd0);
      chk("arst_result_held",
          {bus.result_hi, bus.result_lo}, 64'd0);
      start_op(32'd6, 32'd7, 1'b0, 1'b1);
      wait_done("arst_fresh");
      chk("arst_fresh_lo", {32'b0, bus.result_lo}, 64'd42);
      repeat (3) tick();
      chk("queue_empty", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mult_unit.md
Name: mult_unit

Overview:
- Iterative 32x32 shift-add multiplier for the CPU datapath; produces a 64-bit product as two 32-bit words.
- Sits directly upstream of the 32-bit two-input operand/writeback mux. result_lo or result_hi drives the mux's second data word.
- Multi-cycle with a start/busy/done handshake, so the control unit stalls while busy.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH split into result_hi/result_lo.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a multiply; sampled on the rising edge of clk
- signed_op  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
- operand_a  input  WIDTH  multiplicand; sampled with start
- operand_b  input  WIDTH  multiplier; sampled with start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when results update
- result_lo  output  WIDTH  product bits [WIDTH-1:0]
- result_hi  output  WIDTH  product bits [2*WIDTH-1:WIDTH]

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (rst_n low, async): state=IDLE; busy=0, done=0, result_lo=0, result_hi=0; internal accumulator, counter and sign flag cleared.
- Reset while RUN or FIN aborts the operation. No done pulse. Results stay 0.
- States: IDLE, RUN, FIN.
- IDLE, start=1 at edge E0:
  - Latch |operand_a| and |operand_b|. When signed_op=1, negative operands are two's-complement negated; 0x80000000 yields magnitude 2^31, which fits unsigned.
  - Latch neg = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]).
  - Clear the 2*WIDTH accumulator, set counter=0, go to RUN; busy=1 from after E0.
- RUN, each edge:
  - If multiplier LSB=1, add the shifted multiplicand into the upper accumulator half (WIDTH+1-bit add, carry kept).
  - Shift the accumulator/multiplier right by 1; counter++.
  - After WIDTH iterations (edges E1..E32 for WIDTH=32), go to FIN.
- FIN, edge E33:
  - result = neg ? -acc : acc (2*WIDTH-bit negate).
  - result_hi/result_lo registered; done=1 and busy=0 for the cycle after E33; state=IDLE.
- Latency: exactly WIDTH+1 edges from the start edge to done visible. Fixed, independent of operand values.
- start while busy=1 is ignored. Operands are not re-sampled and the operation in progress is unaffected.
- start high in the cycle where done=1 is accepted, since the state is IDLE. A new RUN begins; result outputs hold the previous product until the next FIN.
- result_hi/result_lo hold their value between operations and change only at FIN or reset.
- done is never high for two consecutive cycles.
- signed_op=0: no negation anywhere; operands are treated as raw unsigned.

Test Plan:
- Unsigned basic: rst_n pulse, then start with a=6, b=7, signed_op=0 -> done 33 cycles after the start edge; result_hi=0x00000000, result_lo=0x0000002A; busy high for exactly 33 cycles.
- Signed negative: a=0xFFFFFFFD (-3), b=5, signed_op=1 -> result_hi=0xFFFFFFFF, result_lo=0xFFFFFFF1.
- Extremes:
  - Unsigned a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
  - Signed a=b=0x80000000 -> hi=0x40000000, lo=0x00000000.
- Start while busy: start a=2, b=3; at cycle 10, pulse start with a=100, b=100 -> result_lo=6, a single done pulse, no second operation.
- Back-to-back: assert start with a=4, b=4 in the done cycle of a 6*7 operation -> first done shows 42; the next done arrives 33 cycles later with 16; lo reads 42 throughout the intervening cycles.
- Async reset mid-op: start 6*7, drop rst_n asynchronously at cycle 15 and release it -> busy=0, done never pulses, result_lo=result_hi=0; a fresh start then completes normally.
